// File: rtl/comp_pkg.sv
// comp_pkg: shared definitions for the comp_arb shared-comparator controller.
//   - CMP_* : 3-bit compare-control encodings (1x0 / 1x1 alias EQ / NE)
//   - comp_state_e : controller FSM states
package comp_pkg;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_LE = 3'b001;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_NE = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StResp
  } comp_state_e;

endpackage

// File: rtl/comp_eval.sv
// comp_eval: purely combinational compare evaluator.
// Ports:
//   a_i, b_i  : operands
//   ctrl_i    : compare control (see comp_pkg CMP_*)
//   uns_i     : 1 = unsigned magnitude compare, 0 = signed two's complement
//   res_o     : single result bit of the selected relation
module comp_eval
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       ctrl_i,
  input  logic             uns_i,
  output logic             res_o
);

  logic grtr;
  logic eql;
  logic lt;

  always_comb begin
    eql = (a_i == b_i);
    if (uns_i) begin
      grtr = (a_i > b_i);
    end else begin
      grtr = ($signed(a_i) > $signed(b_i));
    end
    lt = ~grtr & ~eql;
    // ctrl[2] selects the equality group; ctrl[1] is don't-care there.
    res_o = ctrl_i[2] ? (eql ^ ctrl_i[0])
                      : ((ctrl_i[0] & eql) | (ctrl_i[1] & grtr) | (~ctrl_i[1] & lt));
  end

endmodule

// File: rtl/comp_arb.sv
// comp_arb: two-requester round-robin controller around one shared comparator.
// Optional feature macro: CMP_UNSIGNED_EN (adds uns0/uns1 and unsigned compares).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req[1:0]          : per-requester request, held with stable operands until granted
//   a0/b0/ctrl0       : requester 0 operands and compare control
//   a1/b1/ctrl1       : requester 1 operands and compare control
//   uns0, uns1        : unsigned-compare select (CMP_UNSIGNED_EN only)
//   gnt[1:0]          : one-hot grant pulse, operands captured on that edge
//   rsp_valid/rsp_id  : registered result valid and owning requester
//   rsp_z             : registered result, zero-extended single bit
//   rsp_ready         : consumer accepts the result
module comp_arb
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [2:0]       ctrl0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       ctrl1,
`ifdef CMP_UNSIGNED_EN
  input  logic             uns0,
  input  logic             uns1,
`endif
  output logic [1:0]       gnt,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  input  logic             rsp_ready
);

  comp_state_e      state_q, state_d;
  logic             last_q, last_d;  // requester served most recently
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             id_q, id_d;
  logic             uns_q, uns_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_bit_q, rsp_bit_d;

  logic             win_id;
  logic             eval_res;

  comp_eval #(
    .WIDTH (WIDTH)
  ) u_comp_eval (
    .a_i    (a_q),
    .b_i    (b_q),
    .ctrl_i (ctrl_q),
    .uns_i  (uns_q),
    .res_o  (eval_res)
  );

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 was not the last one left waiting (i.e. 0 was served last).
  assign win_id = req[1] & (~req[0] | ~last_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    id_d        = id_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_bit_d   = rsp_bit_q;
    gnt         = 2'b00;

    unique case (state_q)
      StIdle: begin
        if ((req != 2'b00) && !rst) begin
          gnt     = win_id ? 2'b10 : 2'b01;
          a_d     = win_id ? a1 : a0;
          b_d     = win_id ? b1 : b0;
          ctrl_d  = win_id ? ctrl1 : ctrl0;
          id_d    = win_id;
          last_d  = win_id;
`ifdef CMP_UNSIGNED_EN
          uns_d   = win_id ? uns1 : uns0;
`else
          uns_d   = 1'b0;
`endif
          state_d = StEval;
        end
      end
      StEval: begin
        rsp_bit_d   = eval_res;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;  // so requester 0 wins the first contested grant
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= 3'b000;
      id_q        <= 1'b0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      id_q        <= id_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_bit_q   <= rsp_bit_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = WIDTH'(rsp_bit_q);

endmodule

// File: tb/tb_comp_arb.sv
// tb_comp_arb: self-checking bench for comp_arb with directed cases and
// randomized transactions checked against a transaction-level reference model.
module tb_comp_arb;
  import comp_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   ctrl0, ctrl1;
  logic         uns0, uns1;
  logic [1:0]   gnt;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_z;
  logic         rsp_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: requester served most recently (1 after reset => 0 favoured).
  logic ptr_last;

  always #5 clk = ~clk;

  comp_arb #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .ctrl0     (ctrl0),
    .a1        (a1),
    .b1        (b1),
    .ctrl1     (ctrl1),
`ifdef CMP_UNSIGNED_EN
    .uns0      (uns0),
    .uns1      (uns1),
`endif
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .rsp_ready (rsp_ready)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the relation named by the control code, evaluated directly.
  function automatic logic ref_z(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] c, input logic u);
    logic use_uns;
    logic less;
    logic more;
`ifdef CMP_UNSIGNED_EN
    use_uns = u;
`else
    use_uns = 1'b0;
    if (u) use_uns = 1'b0;
`endif
    less = use_uns ? (a < b) : ($signed(a) < $signed(b));
    more = use_uns ? (a > b) : ($signed(a) > $signed(b));
    if (c[2]) return c[0] ? (a != b) : (a == b);
    case (c[1:0])
      2'd0:    return less;
      2'd1:    return less || (a == b);
      2'd2:    return more;
      default: return more || (a == b);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 15));
      default: return W'($urandom());
    endcase
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req       = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_gnt", W'(gnt), '0);
    check_eq("rst_valid", W'(rsp_valid), '0);
    check_eq("rst_id", W'(rsp_id), '0);
    check_eq("rst_z", rsp_z, '0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ptr_last = 1'b1;
  endtask

  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic run_txn(input logic [1:0] r,
                         input logic [W-1:0] xa0, input logic [W-1:0] xb0, input logic [2:0] c0,
                         input logic u0,
                         input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic [2:0] c1,
                         input logic u1,
                         input int stall, input logic busy_req);
    logic         win;
    logic         z_exp;
    logic [1:0]   g_exp;
    req   = r;
    a0    = xa0; b0 = xb0; ctrl0 = c0; uns0 = u0;
    a1    = xa1; b1 = xb1; ctrl1 = c1; uns1 = u1;
    rsp_ready = 1'b0;
    if (r == 2'b11) win = ~ptr_last;
    else            win = r[1];
    g_exp    = win ? 2'b10 : 2'b01;
    z_exp    = win ? ref_z(xa1, xb1, c1, u1) : ref_z(xa0, xb0, c0, u0);
    ptr_last = win;

    @(negedge clk);  // cycle N
    check_eq("gnt", W'(gnt), W'(g_exp));
    check_eq("valid_at_gnt", W'(rsp_valid), '0);

    @(posedge clk);
    #1;
    // Scramble operands: the captured copy must be used.
    req = busy_req ? 2'b11 : 2'b00;
    a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
    ctrl0 = 3'($urandom()); ctrl1 = 3'($urandom());
    uns0 = 1'($urandom()); uns1 = 1'($urandom());
    @(negedge clk);  // cycle N+1
    check_eq("gnt_eval", W'(gnt), '0);
    check_eq("valid_eval", W'(rsp_valid), '0);

    @(posedge clk);
    #1;
    rsp_ready = (stall == 0);
    @(negedge clk);  // cycle N+2
    check_eq("valid", W'(rsp_valid), 1);
    check_eq("rsp_id", W'(rsp_id), W'(win));
    check_eq("rsp_z", rsp_z, W'(z_exp));
    check_eq("gnt_resp", W'(gnt), '0);

    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      rsp_ready = (i == stall - 1);
      @(negedge clk);
      check_eq("stall_valid", W'(rsp_valid), 1);
      check_eq("stall_id", W'(rsp_id), W'(win));
      check_eq("stall_z", rsp_z, W'(z_exp));
      check_eq("stall_gnt", W'(gnt), '0);
    end

    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req       = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] c;
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    rst = 1'b1; req = '0; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; ctrl0 = '0; ctrl1 = '0; uns0 = 1'b0; uns1 = 1'b0;
    ptr_last = 1'b1;

    do_reset();

    // Single requester 0, 5 < 7.
    run_txn(2'b01, 5, 7, CMP_LT, 0, 0, 0, CMP_LT, 0, 0, 0);

    // Contested requests alternate starting with requester 0.
    do_reset();
    run_txn(2'b11, 3, 3, CMP_EQ, 0, 3, 4, CMP_EQ, 0, 0, 0);
    run_txn(2'b11, 3, 3, CMP_EQ, 0, 3, 4, CMP_EQ, 0, 0, 0);
    run_txn(2'b11, 3, 3, CMP_EQ, 0, 3, 4, CMP_EQ, 0, 0, 0);

    // Signed vs unsigned greater-than on -1 vs 1.
    run_txn(2'b10, 0, 0, CMP_LT, 0, 32'hFFFF_FFFF, 1, CMP_GT, 0, 0, 0);
    run_txn(2'b10, 0, 0, CMP_LT, 0, 32'hFFFF_FFFF, 1, CMP_GT, 1, 0, 0);

    // Five-cycle stall with both requesters pending.
    run_txn(2'b11, 9, 2, CMP_GE, 0, 2, 9, CMP_GE, 0, 5, 1);

    // Reset while evaluating: no response, pointer back to requester 0.
    req = 2'b10; a1 = 1; b1 = 1; ctrl1 = CMP_EQ; rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_gnt", W'(gnt), 2);
    @(posedge clk);
    #1;
    rst = 1'b1; req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_eval_valid", W'(rsp_valid), '0);
      check_eq("rst_eval_id", W'(rsp_id), '0);
      check_eq("rst_eval_z", rsp_z, '0);
      check_eq("rst_eval_gnt", W'(gnt), '0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    ptr_last  = 1'b1;
    run_txn(2'b11, 1, 2, CMP_LT, 0, 2, 1, CMP_LT, 0, 0, 0);

    // Control-code sweep including aliased 110/111.
    pa[0] = 2; pb[0] = 9;
    pa[1] = 9; pb[1] = 9;
    pa[2] = 9; pb[2] = 2;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        c = 3'(k);
        run_txn(2'b01, pa[p], pb[p], c, 0, 0, 0, CMP_LT, 0, 0, 0);
      end
    end

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic [W-1:0] ra0, rb0, ra1, rb1;
      ra0 = rand_op();
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : rand_op();
      ra1 = rand_op();
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : rand_op();
      run_txn(2'($urandom_range(1, 3)),
              ra0, rb0, 3'($urandom()), 1'($urandom()),
              ra1, rb1, 3'($urandom()), 1'($urandom()),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
              1'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
